// File: rtl/timer_tick_scheduler.sv
`timescale 1ns/1ps
// Programs an interval timer, then turns its timeouts into tick and per-channel divided ticks.
// Latency: first timer write one cycle after reset release; tick in the cycle after tmr_irq; ch_tick one cycle after tick.
// Backpressure: none; timer writes are zero-wait-state and reprogram requests are held pending (last value wins).
module timer_tick_scheduler #(
    parameter logic [31:0] DEFAULT_PERIOD = 32'd49999
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] cfg_period,
    input  logic        cfg_valid,
    input  logic [3:0]  ch_en,
    input  logic [31:0] ch_div,
    output logic [2:0]  tmr_address,
    output logic        tmr_chipselect,
    output logic        tmr_write_n,
    output logic [15:0] tmr_writedata,
    input  logic        tmr_irq,
    output logic        tick,
    output logic [3:0]  ch_tick,
    output logic        busy
);

    typedef enum logic [2:0] {
        INIT,
        STOP,
        WR_PL,
        WR_PH,
        WR_ST,
        WR_CTRL,
        RUN,
        CLR
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] period_act;
    logic [31:0] pend_val;
    logic        pend_flag;
    logic        stop_entry;
    logic [7:0]  cnt [4];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // A timeout always wins over a waiting reprogram; the request is served on a later RUN cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    state_nxt = WR_PL;
            STOP:    state_nxt = WR_PL;
            WR_PL:   state_nxt = WR_PH;
            WR_PH:   state_nxt = WR_ST;
            WR_ST:   state_nxt = WR_CTRL;
            WR_CTRL: state_nxt = RUN;
            RUN: begin
                if (tmr_irq) begin
                    state_nxt = CLR;
                end else if (pend_flag) begin
                    state_nxt = STOP;
                end
            end
            CLR:     state_nxt = RUN;
            default: state_nxt = INIT;
        endcase
    end

    assign stop_entry = (state == RUN) && !tmr_irq && pend_flag;

    always_comb begin
        tmr_chipselect = 1'b0;
        tmr_address    = 3'd0;
        tmr_writedata  = 16'h0000;
        case (state)
            STOP: begin
                tmr_chipselect = 1'b1;
                tmr_address    = 3'd1;
                tmr_writedata  = 16'h0008;
            end
            WR_PL: begin
                tmr_chipselect = 1'b1;
                tmr_address    = 3'd2;
                tmr_writedata  = period_act[15:0];
            end
            WR_PH: begin
                tmr_chipselect = 1'b1;
                tmr_address    = 3'd3;
                tmr_writedata  = period_act[31:16];
            end
            WR_ST: begin
                tmr_chipselect = 1'b1;
                tmr_address    = 3'd0;
                tmr_writedata  = 16'h0000;
            end
            WR_CTRL: begin
                tmr_chipselect = 1'b1;
                tmr_address    = 3'd1;
                tmr_writedata  = 16'h0007;
            end
            CLR: begin
                tmr_chipselect = 1'b1;
                tmr_address    = 3'd0;
                tmr_writedata  = 16'h0000;
            end
            default: begin
                tmr_chipselect = 1'b0;
            end
        endcase
    end

    assign tmr_write_n = ~tmr_chipselect;
    assign tick        = (state == CLR);
    assign busy        = (state != RUN) && (state != CLR);

    // A request arriving on the STOP-entry edge stays pending for the next round.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_act <= DEFAULT_PERIOD;
            pend_val   <= 32'd0;
            pend_flag  <= 1'b0;
        end else begin
            if (stop_entry) begin
                period_act <= pend_val;
                pend_flag  <= 1'b0;
            end
            if (cfg_valid) begin
                pend_val  <= cfg_period;
                pend_flag <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 4; k++) begin
                cnt[k] <= 8'd0;
            end
            ch_tick <= 4'd0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                ch_tick[k] <= 1'b0;
                if (stop_entry || !ch_en[k]) begin
                    cnt[k] <= 8'd0;
                end else if (tick) begin
                    // Equality match only: a counter above a newly lowered divisor wraps through 255.
                    if (cnt[k] == ch_div[8*k +: 8]) begin
                        ch_tick[k] <= 1'b1;
                        cnt[k]     <= 8'd0;
                    end else begin
                        cnt[k] <= cnt[k] + 8'd1;
                    end
                end
            end
        end
    end

endmodule
